lifo_pop_ctrl: RTL and testbench

//   Read-side controller for the 8-entry push/pc LIFO (control + reg_dff + salida path).

---
 rtl/lifo_pop_ctrl.sv | 159 +++++++++++++++
 tb/tb_lifo_pop_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_pop_ctrl.sv
// ---------------------------------------------------------------------------
// lifo_pop_ctrl
//   Read-side controller for the 8-entry push/pc LIFO. It issues single-cycle
//   pop strobes to the stack control, captures the top-of-stack word, and
//   offers each popped word on a valid/ready output stream. Single pops come
//   from pop_req. A full drain comes from drain_req. A pop request on an
//   empty stack raises a sticky underflow flag.
//
// Ports
//   clk         in   1    rising-edge clock for all state
//   reset       in   1    synchronous, active-high reset
//   pop_req     in   1    request one pop (looked at only while idle)
//   drain_req   in   1    request a pop of every entry (looked at only while idle)
//   stk_pc      in   PCW  stack occupancy (0 = empty)
//   stk_data    in   DW   current top-of-stack word
//   stk_pop     out  1    one-cycle pop strobe to the stack control
//   out_data    out  DW   popped word
//   out_valid   out  1    out_data valid, held until accepted
//   out_ready   in   1    downstream accepts when out_valid & out_ready
//   busy        out  1    controller is not idle
//   drain_done  out  1    one-cycle pulse when a drain finds the stack empty
//   underflow   out  1    sticky: pop_req seen while the stack was empty
//   popped_cnt  out  PCW  number of accepted words, wraps modulo 2^PCW
// ---------------------------------------------------------------------------
module lifo_pop_ctrl #(
    parameter int DW    = 4,
    parameter int DEPTH = 8,
    parameter int PCW   = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pop_req,
    input  logic           drain_req,
    input  logic [PCW-1:0] stk_pc,
    input  logic [DW-1:0]  stk_data,
    output logic           stk_pop,
    output logic [DW-1:0]  out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           drain_done,
    output logic           underflow,
    output logic [PCW-1:0] popped_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [PCW-1:0] MAX_PC = PCW'(DEPTH);

    logic [1:0]     state_q, state_d;
    logic           stk_pop_q, stk_pop_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           drain_q, drain_d;
    logic           drain_done_q, drain_done_d;
    logic           underflow_q, underflow_d;
    logic [PCW-1:0] popped_cnt_q, popped_cnt_d;
    logic           busy_q, busy_d;

    logic go;
    logic stk_has_data;

    // The pending drain flag keeps a drain running across its IDLE visits.
    // An occupancy above DEPTH cannot happen, so it is treated as empty.
    // This keeps a corrupt count from starting stack reads.
    assign go           = drain_req | drain_q | pop_req;
    assign stk_has_data = (stk_pc != '0) && (stk_pc <= MAX_PC);

    // Next-state logic. In IDLE, the drain branch comes before the single-pop
    // branch. As a result, a pop_req that arrives with drain_req does not
    // cause an extra pop. An empty-stack drain ends the drain and does not
    // set underflow.
    always_comb begin
        state_d      = state_q;
        stk_pop_d    = 1'b0;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        drain_d      = drain_q;
        drain_done_d = 1'b0;
        underflow_d  = underflow_q;
        popped_cnt_d = popped_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (drain_req) begin
                    drain_d = 1'b1;
                end
                if (go && stk_has_data) begin
                    out_data_d  = stk_data;
                    out_valid_d = 1'b1;
                    stk_pop_d   = 1'b1;
                    state_d     = ST_POP;
                end else if (drain_req || drain_q) begin
                    drain_d      = 1'b0;
                    drain_done_d = 1'b1;
                end else if (pop_req) begin
                    underflow_d = 1'b1;
                end
            end
            ST_POP: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    popped_cnt_d = popped_cnt_q + PCW'(1);
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    popped_cnt_d = popped_cnt_q + PCW'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State registers. The synchronous reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            stk_pop_q    <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            drain_q      <= 1'b0;
            drain_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            popped_cnt_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stk_pop_q    <= stk_pop_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            drain_q      <= drain_d;
            drain_done_q <= drain_done_d;
            underflow_q  <= underflow_d;
            popped_cnt_q <= popped_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign stk_pop    = stk_pop_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign drain_done = drain_done_q;
    assign underflow  = underflow_q;
    assign popped_cnt = popped_cnt_q;

endmodule

// File: tb/tb_lifo_pop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lifo_pop_ctrl
//   Bench for lifo_pop_ctrl. A simple stack model supplies stk_pc and
//   stk_data, and it decrements on every stk_pop pulse. A scoreboard queue
//   records the word that should leave for each pop. The stream is then
//   checked word by word against that queue. Expected counters (accepted
//   words, underflow, drain completions) are kept as plain integers.
// ---------------------------------------------------------------------------
module tb_lifo_pop_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pop_req = 1'b0;
    logic       drain_req = 1'b0;
    logic [3:0] stk_pc;
    logic [3:0] stk_data;
    logic       stk_pop;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       drain_done;
    logic       underflow;
    logic [3:0] popped_cnt;

    lifo_pop_ctrl #(.DW(4), .DEPTH(8), .PCW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pop_req    (pop_req),
        .drain_req  (drain_req),
        .stk_pc     (stk_pc),
        .stk_data   (stk_data),
        .stk_pop    (stk_pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .drain_done (drain_done),
        .underflow  (underflow),
        .popped_cnt (popped_cnt)
    );

    always #5 clk = ~clk;

    // Stack model: index pc-1 holds the top word. A pop takes effect at the
    // end of the cycle in which stk_pop is high.
    logic [3:0] stk_mem [0:7];
    logic [3:0] pc_m = 4'd0;
    logic       load_en = 1'b0;
    logic [3:0] load_cnt = 4'd0;

    always @(posedge clk) begin
        if (load_en) pc_m <= load_cnt;
        else if (stk_pop && pc_m != 4'd0) pc_m <= pc_m - 4'd1;
    end

    assign stk_pc   = pc_m;
    assign stk_data = (pc_m != 4'd0) ? stk_mem[3'(pc_m - 4'd1)] : 4'd0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_total = 0;
    int n_done = 0;
    int txn_pops = 0;
    int txn_acc = 0;
    bit exp_uf = 1'b0;
    bit stalling = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] acc_log[$];

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock, then sample #1 after the edge and update the model.
    // Acceptance is decided by valid/ready just before the edge.
    task automatic tick();
        bit acc;
        bit was_reset;
        bit prev_valid;
        bit prev_pop;
        logic [3:0] prev_data;
        acc        = out_valid && out_ready;
        was_reset  = reset;
        prev_valid = out_valid;
        prev_pop   = stk_pop;
        prev_data  = out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (was_reset) begin
            exp_q.delete();
            acc_total = 0;
            exp_uf = 1'b0;
        end else if (acc) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_accept", 1, 0);
            end else begin
                checkOutput("stream_word", prev_data, exp_q.pop_front());
            end
            acc_total++;
            txn_acc++;
            acc_log.push_back(prev_data);
        end else if (prev_valid) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_data", out_data, prev_data);
        end
        if (stk_pop) begin
            txn_pops++;
            checkOutput("pop_pulse", prev_pop, 0);
            if (pc_m != 4'd0) begin
                checkOutput("captured_top", out_data, stk_mem[3'(pc_m - 4'd1)]);
                exp_q.push_back(stk_mem[3'(pc_m - 4'd1)]);
            end else begin
                checkOutput("pop_on_empty", 1, 0);
            end
        end
        if (drain_done) n_done++;
        checkOutput("popped_cnt", popped_cnt, acc_total % 16);
        checkOutput("underflow", underflow, exp_uf);
    endtask

    task automatic load_stack(input int cnt, input bit seq);
        for (int i = 0; i < 8; i++) stk_mem[i] = seq ? 4'(i) : 4'($urandom_range(0, 15));
        load_cnt = 4'(cnt);
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
    endtask

    // One pop or drain transaction, with a ready mode:
    //   0 ready always high; 1 random ready; 2 stall the second word 3 cycles;
    //   3 reset after two accepted words; 4 re-request while busy.
    task automatic applyStimulus(input bit is_drain, input int mode);
        int pc0;
        int done_before;
        int budget;
        int stall_left;
        int last_pop_cyc;
        int pc0_cyc;
        bit done;
        pc0 = int'(pc_m);
        done_before = n_done;
        txn_pops = 0;
        txn_acc = 0;
        stall_left = 3;
        last_pop_cyc = -1;
        pc0_cyc = -1;
        budget = 0;
        acc_log.delete();
        if (!is_drain && pc0 == 0) exp_uf = 1'b1;
        pop_req = !is_drain;
        drain_req = is_drain;
        tick();
        pop_req = 1'b0;
        drain_req = 1'b0;
        if (pc0 != 0) begin
            checkOutput("lat_valid", out_valid, 1);
            checkOutput("lat_pop", stk_pop, 1);
            checkOutput("lat_busy", busy, 1);
            last_pop_cyc = cyc;
        end else begin
            checkOutput("empty_no_pop", stk_pop, 0);
            checkOutput("empty_busy", busy, 0);
            if (is_drain) checkOutput("empty_drain_done", drain_done, 1);
        end
        done = is_drain ? (n_done != done_before) : !out_valid;
        while (!done && budget < 300) begin
            case (mode)
                0: out_ready = 1'b1;
                2: begin
                    if (txn_pops == 2 && out_valid && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                        checkOutput("stall_word", out_data, 3);
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                4: begin
                    out_ready = (budget != 0);
                    if (out_valid) pop_req = 1'b1;
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 3 && txn_acc == 2) begin
                out_ready = 1'b1;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                checkOutput("rst_stk_pop", stk_pop, 0);
                checkOutput("rst_out_valid", out_valid, 0);
                checkOutput("rst_out_data", out_data, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_drain_done", drain_done, 0);
                for (int i = 0; i < 4; i++) tick();
                checkOutput("rst_abort_pc", pc_m, 3);
                checkOutput("rst_abort_busy", busy, 0);
                checkOutput("rst_abort_pops", txn_pops, 2);
                return;
            end
            tick();
            pop_req = 1'b0;
            budget++;
            if (stk_pop && mode == 0 && is_drain) begin
                checkOutput("drain_rate", cyc - last_pop_cyc, 2);
                last_pop_cyc = cyc;
            end
            if (pc_m == 4'd0 && pc0_cyc < 0) pc0_cyc = cyc;
            done = is_drain ? (n_done != done_before) : !out_valid;
        end
        out_ready = 1'b1;
        checkOutput("txn_bound", done, 1);
        checkOutput("txn_pops", txn_pops, is_drain ? pc0 : (pc0 != 0 ? 1 : 0));
        checkOutput("txn_accepts", txn_acc, is_drain ? pc0 : (pc0 != 0 ? 1 : 0));
        checkOutput("txn_pc", pc_m, is_drain ? 0 : (pc0 != 0 ? pc0 - 1 : 0));
        checkOutput("txn_idle", busy, 0);
        if (is_drain && mode == 0 && pc0 != 0) checkOutput("done_after_empty", cyc - pc0_cyc, 1);
        tick();
        checkOutput("done_pulse", drain_done, 0);
        checkOutput("drain_count", n_done - done_before, is_drain ? 1 : 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) stk_mem[i] = 4'd0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_stk_pop", stk_pop, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_data", out_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", drain_done, 0);

        // Single pop from a five-entry stack.
        load_stack(5, 1'b1);
        applyStimulus(1'b0, 0);
        checkOutput("single_word", (acc_log.size() > 0) ? int'(acc_log[0]) : -1, 4);
        checkOutput("single_cnt", popped_cnt, 1);

        // Full drain with ready held high.
        load_stack(5, 1'b1);
        applyStimulus(1'b1, 0);
        checkOutput("drain_len", acc_log.size(), 5);
        for (int i = 0; i < 5 && i < acc_log.size(); i++) checkOutput("drain_order", acc_log[i], 4 - i);
        checkOutput("drain_cnt", popped_cnt, 6);

        // Drain with the second word stalled for three cycles.
        load_stack(5, 1'b1);
        applyStimulus(1'b1, 2);
        checkOutput("stall_len", acc_log.size(), 5);
        for (int i = 0; i < 5 && i < acc_log.size(); i++) checkOutput("stall_order", acc_log[i], 4 - i);

        // Empty stack: pop raises sticky underflow, drain only pulses done.
        load_stack(0, 1'b1);
        applyStimulus(1'b0, 0);
        checkOutput("underflow_set", underflow, 1);
        applyStimulus(1'b1, 0);
        checkOutput("underflow_kept", underflow, 1);

        // Reset in the middle of a drain.
        load_stack(5, 1'b1);
        applyStimulus(1'b1, 3);

        // Eighteen single pops wrap the accepted-word counter.
        for (int i = 0; i < 18; i++) begin
            if (pc_m == 4'd0) load_stack(8, 1'b0);
            applyStimulus(1'b0, (i == 5) ? 4 : 0);
        end
        checkOutput("cnt_wrap", popped_cnt, 2);

        // Randomized mix of loads, pops, drains and ready patterns.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) load_stack($urandom_range(0, 8), 1'b0);
            applyStimulus($urandom_range(0, 2) == 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
